// File: rtl/bcd_grant_arbiter.sv
// Round-robin arbiter for 10 requesters sharing a 4-to-10 decoder; grants as BCD code plus one-hot.
// Optional BCD_ARB_FIXED_PRIO_EN: replace round-robin search with fixed lowest-index priority.
module bcd_grant_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req,
  input  logic       done,
  output logic [3:0] gnt_code,
  output logic       gnt_valid,
  output logic [9:0] gnt_onehot,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       winner;
  logic             owner_req;
  logic             at_limit;

`ifdef BCD_ARB_FIXED_PRIO_EN
  // Lowest active index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    winner = '0;
    for (int i = 9; i >= 0; i--) begin
      if (req[4'(i)]) winner = 4'(i);
    end
  end
`else
  logic [3:0] last;
  logic [3:0] idx;
  logic       found;

  // Search from last+1 with decimal wrap, so the previous owner is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 10; i++) begin
      idx = 4'((int'(last) + i) % 10);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  assign owner_req = req[gnt_code];
  assign at_limit  = (hold_cnt == CNT_W'(HOLD_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_code   <= '0;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
`ifndef BCD_ARB_FIXED_PRIO_EN
      last       <= 4'd9;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_code   <= winner;
            gnt_onehot <= 10'b1 << winner;
            gnt_valid  <= 1'b1;
            hold_cnt   <= CNT_W'(1);
            state      <= GRANT;
          end else begin
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
          end
        end
        GRANT: begin
          if (done || !owner_req || at_limit) begin
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            // Timeout only when the hold limit alone forced the release.
            timeout    <= !done && owner_req;
`ifndef BCD_ARB_FIXED_PRIO_EN
            last       <= gnt_code;
`endif
            state      <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_grant_arbiter.sv
// Directed bench for bcd_grant_arbiter: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_bcd_grant_arbiter;

  localparam int unsigned HOLD = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] req;
  logic       done;
  logic [3:0] gnt_code;
  logic       gnt_valid;
  logic [9:0] gnt_onehot;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  bcd_grant_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_code(gnt_code), .gnt_valid(gnt_valid),
    .gnt_onehot(gnt_onehot), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = bus free), cycles held, previous owner.
  int m_owner = -1;
  int m_code  = 0;
  int m_held  = 0;
  int m_last  = 9;
  bit m_tout  = 1'b0;
  bit live    = 1'b0;

  function automatic int pick(input logic [9:0] r, input int last);
`ifdef BCD_ARB_FIXED_PRIO_EN
    for (int c = 0; c < 10; c++) if (r[c]) return c;
`else
    for (int k = 1; k <= 10; k++) if (r[(last + k) % 10]) return (last + k) % 10;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_code = 0; m_held = 0; m_last = 9; m_tout = 1'b0; live = 1'b1;
    end else if (m_owner < 0) begin
      m_tout = 1'b0;
      if (req != 10'd0) begin
        m_owner = pick(req, m_last);
        m_code  = m_owner;
        m_held  = 1;
      end
    end else begin
      m_tout = 1'b0;
      if (done || !req[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (m_held >= int'(HOLD)) begin
        m_tout = 1'b1; m_last = m_owner; m_owner = -1;
      end else begin
        m_held++;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle after reset, plus structural invariants.
  always @(negedge clk) begin
    if (live) begin
      logic [9:0] e_oh;
      e_oh = (m_owner >= 0) ? (10'b1 << m_owner) : 10'd0;
      chk("cycle_model", {gnt_code, gnt_valid, gnt_onehot, timeout},
          {4'(m_code), m_owner >= 0, e_oh, m_tout});
      chk("onehot_max1", 16'($countones(gnt_onehot) <= 1), 16'd1);
      chk("code_le_9", 16'(gnt_code <= 4'd9), 16'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int k;
    k = 0;
    while (!gnt_valid && k < 20) begin
      step(1);
      k++;
    end
    if (!gnt_valid) begin
      n_vec++; n_err++;
      $display("FAIL %s: no grant within 20 cycles, gnt_valid=%b expected 1", name, gnt_valid);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; req = '0; done = 1'b0;
    step(1);
    chk("reset_state", 16'({gnt_code, gnt_valid, gnt_onehot, timeout}), 16'h0000);

    // Single requester 0, done on 4th grant cycle.
    rst = 1'b0; req = 10'h001;
    step(1);
    chk("t1_grant", 16'({gnt_code, gnt_valid, gnt_onehot}), 16'({4'd0, 1'b1, 10'h001}));
    step(3);
    done = 1'b1;
    step(1);
    chk("t1_release", 16'({gnt_valid, timeout}), 16'b00);
    done = 1'b0; req = '0;
    step(2);

`ifndef BCD_ARB_FIXED_PRIO_EN
    // All requesting, done every grant: order 0..9,0 with an idle cycle between.
    rst = 1'b1; step(1); rst = 1'b0; req = 10'h3FF;
    step(1);
    for (int g = 0; g <= 10; g++) begin
      chk("t2_order", 16'({gnt_valid, gnt_code}), 16'({1'b1, 4'(g % 10)}));
      done = 1'b1; step(1);
      chk("t2_gap", 16'(gnt_valid), 16'd0);
      done = 1'b0; step(1);
    end
    req = '0; step(2);
`endif

    // Hold limit on requester 5.
    req = 10'h020;
    wait_grant("t3_wait");
    cnt = 0;
    while (gnt_valid && cnt < 40) begin
      cnt++;
      step(1);
    end
    chk("t3_hold_len", 16'(cnt), 16'(HOLD));
    chk("t3_timeout", 16'(timeout), 16'd1);
    step(1);
    chk("t3_regrant", 16'({gnt_valid, gnt_code, timeout}), 16'({1'b1, 4'd5, 1'b0}));
    req = '0; step(2);

`ifndef BCD_ARB_FIXED_PRIO_EN
    // Owner 7 drops request while 2 waits.
    req = 10'h084; step(1);
    chk("t4_grant7", 16'({gnt_valid, gnt_code}), 16'({1'b1, 4'd7}));
    step(1);
    req = 10'h004; step(1);
    chk("t4_drop", 16'({gnt_valid, timeout}), 16'b00);
    step(1);
    chk("t4_grant2", 16'({gnt_valid, gnt_code}), 16'({1'b1, 4'd2}));
    req = '0; step(2);
`endif

    // Reset mid-grant to 3, then search restarts at 0.
    req = 10'h008;
    wait_grant("t5_wait");
    chk("t5_grant3", 16'(gnt_code), 16'd3);
    rst = 1'b1; step(1);
    chk("t5_reset", 16'({gnt_code, gnt_valid, gnt_onehot, timeout}), 16'h0000);
    rst = 1'b0; step(1);
    chk("t5_after", 16'({gnt_valid, gnt_code, gnt_onehot}), 16'({1'b1, 4'd3, 10'h008}));

    // done coinciding with the hold limit suppresses timeout.
    step(14);
    done = 1'b1; step(1);
    chk("t7_done_at_limit", 16'({gnt_valid, timeout}), 16'b00);
    done = 1'b0; req = '0; step(2);

`ifdef BCD_ARB_FIXED_PRIO_EN
    // Fixed priority: 4 always beats 9.
    rst = 1'b1; step(1); rst = 1'b0; req = 10'h210;
    for (int g = 0; g < 4; g++) begin
      wait_grant("t6_wait");
      chk("t6_prio", 16'(gnt_code), 16'd4);
      done = 1'b1; step(1);
      chk("t6_gap", 16'(gnt_valid), 16'd0);
      done = 1'b0; step(1);
    end
    req = '0; step(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
